// File: rtl/carry_lookahead_adder.sv
// +----------------------------------------------------------------------------+
// | carry_lookahead_adder : registered two/three-level 4-ary carry-lookahead    |
// | adder with word propagate/generate and signed overflow. Rev 1.0            |
// +----------------------------------------------------------------------------+
`default_nettype none

module carry_lookahead_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             Cout,
  output logic             ovf,
  output logic             grp_p,
  output logic             grp_g,
  output logic             out_valid
);

  localparam int NG1 = WIDTH / 4;
  localparam int NG2 = (NG1 + 3) / 4;

  // Carry into position n (0..4) of a 4-wide block; each product term is built
  // independently so the result is a flat sum-of-products, never a chain.
  function automatic logic la_carry(input logic [3:0] p, input logic [3:0] g,
                                    input logic c0, input int n);
    logic c;
    logic term;
    c = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (j < n) begin
        term = g[j];
        for (int m = j + 1; m < 4; m++) begin
          if (m < n) term = term & p[m];
        end
        c = c | term;
      end
    end
    term = c0;
    for (int m = 0; m < 4; m++) begin
      if (m < n) term = term & p[m];
    end
    return c | term;
  endfunction

  logic [WIDTH-1:0] p_bit;
  logic [WIDTH-1:0] g_bit;
  logic [WIDTH-1:0] c_bit;
  logic [4*NG2-1:0] p_grp;
  logic [4*NG2-1:0] g_grp;
  logic [3:0]       p_sup;
  logic [3:0]       g_sup;
  logic [NG2-1:0]   c_sup;
  logic [NG1-1:0]   c_grp;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             ovf_d;
  logic             prop_d;
  logic             gen_d;

  always_comb begin
    p_bit = a ^ b;
    g_bit = a & b;
    // Unused upper slots are padded with P=1/G=0 so they pass carries through
    // and leave the word-level propagate/generate unchanged.
    p_grp = '1;
    g_grp = '0;
    for (int k = 0; k < NG1; k++) begin
      p_grp[k] = &p_bit[4*k +: 4];
      g_grp[k] = la_carry(p_bit[4*k +: 4], g_bit[4*k +: 4], 1'b0, 4);
    end
    p_sup = '1;
    g_sup = '0;
    for (int j = 0; j < NG2; j++) begin
      p_sup[j] = &p_grp[4*j +: 4];
      g_sup[j] = la_carry(p_grp[4*j +: 4], g_grp[4*j +: 4], 1'b0, 4);
    end
    c_sup = '0;
    for (int j = 0; j < NG2; j++) begin
      c_sup[j] = la_carry(p_sup, g_sup, cin, j);
    end
    c_grp = '0;
    for (int k = 0; k < NG1; k++) begin
      c_grp[k] = la_carry(p_grp[4*(k/4) +: 4], g_grp[4*(k/4) +: 4], c_sup[k/4], k % 4);
    end
    c_bit = '0;
    for (int i = 0; i < WIDTH; i++) begin
      c_bit[i] = la_carry(p_bit[4*(i/4) +: 4], g_bit[4*(i/4) +: 4], c_grp[i/4], i % 4);
    end
    sum_d  = p_bit ^ c_bit;
    cout_d = la_carry(p_sup, g_sup, cin, 4);
    gen_d  = la_carry(p_sup, g_sup, 1'b0, 4);
    prop_d = &p_sup;
    ovf_d  = cout_d ^ c_bit[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= '0;
      Cout      <= 1'b0;
      ovf       <= 1'b0;
      grp_p     <= 1'b0;
      grp_g     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum   <= sum_d;
        Cout  <= cout_d;
        ovf   <= ovf_d;
        grp_p <= prop_d;
        grp_g <= gen_d;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_carry_lookahead_adder.sv
// +----------------------------------------------------------------------------+
// | tb_carry_lookahead_adder : scoreboard bench for 4/32/64-bit adder instances |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_carry_lookahead_adder;

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        gp;
    logic        gg;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, cin;
  logic [3:0]  a4, b4, sum4;
  logic [31:0] a32, b32, sum32;
  logic [63:0] a64, b64, sum64;
  logic        cout4, ovf4, gp4, gg4, ov4;
  logic        cout32, ovf32, gp32, gg32, ov32;
  logic        cout64, ovf64, gp64, gg64, ov64;
  logic [8:0]  obs4;
  logic [37:0] obs32;
  logic [69:0] obs64;

  assign obs4  = {sum4, cout4, ovf4, gp4, gg4, ov4};
  assign obs32 = {sum32, cout32, ovf32, gp32, gg32, ov32};
  assign obs64 = {sum64, cout64, ovf64, gp64, gg64, ov64};

  carry_lookahead_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a4), .b(b4), .cin(cin),
    .sum(sum4), .Cout(cout4), .ovf(ovf4), .grp_p(gp4), .grp_g(gg4), .out_valid(ov4));
  carry_lookahead_adder #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a32), .b(b32), .cin(cin),
    .sum(sum32), .Cout(cout32), .ovf(ovf32), .grp_p(gp32), .grp_g(gg32), .out_valid(ov32));
  carry_lookahead_adder #(.WIDTH(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a64), .b(b64), .cin(cin),
    .sum(sum64), .Cout(cout64), .ovf(ovf64), .grp_p(gp64), .grp_g(gg64), .out_valid(ov64));

  int n_checks = 0;
  int n_fails  = 0;
  logic [8:0]  q4[$];
  logic [37:0] q32[$];
  logic [69:0] q64[$];
  logic [8:0]  e4, last4;
  logic [37:0] e32, last32;
  logic [69:0] e64, last64;

  // Behavioural reference: plain addition, overflow from the operand/result sign rule.
  function automatic exp_t model(input logic [63:0] x, input logic [63:0] y,
                                 input logic ci, input int w);
    logic [63:0] mask;
    logic [64:0] full, nocin;
    exp_t r;
    mask  = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    full  = {1'b0, x & mask} + {1'b0, y & mask} + {64'd0, ci};
    nocin = {1'b0, x & mask} + {1'b0, y & mask};
    r.sum  = full[63:0] & mask;
    r.cout = full[w];
    r.gg   = nocin[w];
    r.ovf  = (x[w-1] == y[w-1]) && (r.sum[w-1] != x[w-1]);
    r.gp   = &((x ^ y) | ~mask);
    return r;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic drive(input logic v, input logic [3:0] xa4, input logic [3:0] xb4,
                       input logic [31:0] xa32, input logic [31:0] xb32,
                       input logic [63:0] xa64, input logic [63:0] xb64,
                       input logic ci, input bit push4);
    exp_t e;
    in_valid = v; cin = ci;
    a4 = xa4; b4 = xb4; a32 = xa32; b32 = xb32; a64 = xa64; b64 = xb64;
    if (v) begin
      if (push4) begin
        e = model({60'd0, xa4}, {60'd0, xb4}, ci, 4);
        q4.push_back({e.sum[3:0], e.cout, e.ovf, e.gp, e.gg, 1'b1});
      end
      e = model({32'd0, xa32}, {32'd0, xb32}, ci, 32);
      q32.push_back({e.sum[31:0], e.cout, e.ovf, e.gp, e.gg, 1'b1});
      e = model(xa64, xb64, ci, 64);
      q64.push_back({e.sum, e.cout, e.ovf, e.gp, e.gg, 1'b1});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    rst_n = 1'b0; in_valid = 1'b1; cin = 1'b1;
    a4 = 4'hF; b4 = 4'hF; a32 = '1; b32 = '1; a64 = '1; b64 = '1;
    #1;
    n_checks++; if (obs4 !== 9'd0) begin n_fails++; $display("FAIL reset_async_w4: got %h expected %h", obs4, 9'd0); end
    n_checks++; if (obs32 !== 38'd0) begin n_fails++; $display("FAIL reset_async_w32: got %h expected %h", obs32, 38'd0); end
    n_checks++; if (obs64 !== 70'd0) begin n_fails++; $display("FAIL reset_async_w64: got %h expected %h", obs64, 70'd0); end
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (obs4 !== 9'd0) begin n_fails++; $display("FAIL reset_held_w4: got %h expected %h", obs4, 9'd0); end
    n_checks++; if (obs64 !== 70'd0) begin n_fails++; $display("FAIL reset_held_w64: got %h expected %h", obs64, 70'd0); end
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
  endtask

  task automatic test_zero();
    q4.push_back({4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    drive(1'b1, 4'd0, 4'd0, 32'd0, 32'd0, 64'd0, 64'd0, 1'b0, 1'b0);
    e4 = q4.pop_front(); e32 = q32.pop_front(); e64 = q64.pop_front();
    n_checks++; if (obs4 !== e4) begin n_fails++; $display("FAIL zero_w4: got %h expected %h", obs4, e4); end
    n_checks++; if (obs32 !== e32) begin n_fails++; $display("FAIL zero_w32: got %h expected %h", obs32, e32); end
    n_checks++; if (obs64 !== e64) begin n_fails++; $display("FAIL zero_w64: got %h expected %h", obs64, e64); end
  endtask

  task automatic test_directed();
    logic [3:0] ta[4], tb_[4];
    logic       tc[4];
    logic [8:0] te[4];
    ta[0] = 4'b0010; tb_[0] = 4'b0110; tc[0] = 1'b1; te[0] = {4'd9,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    ta[1] = 4'b1111; tb_[1] = 4'b1101; tc[1] = 1'b0; te[1] = {4'd12, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    ta[2] = 4'b1010; tb_[2] = 4'b0101; tc[2] = 1'b0; te[2] = {4'd15, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    ta[3] = 4'b0011; tb_[3] = 4'b1100; tc[3] = 1'b1; te[3] = {4'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      q4.push_back(te[i]);
      drive(1'b1, ta[i], tb_[i], $urandom, $urandom, rnd64(), rnd64(), tc[i], 1'b0);
      e4 = q4.pop_front(); e32 = q32.pop_front(); e64 = q64.pop_front();
      n_checks++; if (obs4 !== e4) begin n_fails++; $display("FAIL directed_w4[%0d]: got %h expected %h", i, obs4, e4); end
      n_checks++; if (obs32 !== e32) begin n_fails++; $display("FAIL directed_w32[%0d]: got %h expected %h", i, obs32, e32); end
      n_checks++; if (obs64 !== e64) begin n_fails++; $display("FAIL directed_w64[%0d]: got %h expected %h", i, obs64, e64); end
      last4 = e4; last32 = e32; last64 = e64;
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'($urandom), 4'($urandom), $urandom, $urandom, rnd64(), rnd64(), 1'($urandom), 1'b1);
      n_checks++; if (obs4 !== {last4[8:1], 1'b0}) begin n_fails++; $display("FAIL hold_w4[%0d]: got %h expected %h", i, obs4, {last4[8:1], 1'b0}); end
      n_checks++; if (obs32 !== {last32[37:1], 1'b0}) begin n_fails++; $display("FAIL hold_w32[%0d]: got %h expected %h", i, obs32, {last32[37:1], 1'b0}); end
      n_checks++; if (obs64 !== {last64[69:1], 1'b0}) begin n_fails++; $display("FAIL hold_w64[%0d]: got %h expected %h", i, obs64, {last64[69:1], 1'b0}); end
    end
  endtask

  task automatic test_exhaustive();
    logic [3:0] xa, xb;
    logic       xc;
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          xa = 4'(ai); xb = 4'(bi); xc = 1'(ci);
          drive(1'b1, xa, xb, $urandom, $urandom, rnd64(), rnd64(), xc, 1'b1);
          e4 = q4.pop_front(); e32 = q32.pop_front(); e64 = q64.pop_front();
          n_checks++; if (obs4 !== e4) begin n_fails++; $display("FAIL exh_w4 a=%h b=%h c=%b: got %h expected %h", xa, xb, xc, obs4, e4); end
          n_checks++; if (obs32 !== e32) begin n_fails++; $display("FAIL exh_w32: got %h expected %h", obs32, e32); end
          n_checks++; if (obs64 !== e64) begin n_fails++; $display("FAIL exh_w64: got %h expected %h", obs64, e64); end
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    drive(1'b1, 4'($urandom), 4'($urandom), $urandom, $urandom, rnd64(), rnd64(), 1'b1, 1'b1);
    e4 = q4.pop_front(); e32 = q32.pop_front(); e64 = q64.pop_front();
    n_checks++; if (obs64 !== e64) begin n_fails++; $display("FAIL pre_reset_w64: got %h expected %h", obs64, e64); end
    in_valid = 1'b1; a4 = 4'hF; b4 = 4'h1; a32 = $urandom; b32 = $urandom; a64 = rnd64(); b64 = rnd64();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (obs4 !== 9'd0) begin n_fails++; $display("FAIL midreset_async_w4: got %h expected %h", obs4, 9'd0); end
    n_checks++; if (obs32 !== 38'd0) begin n_fails++; $display("FAIL midreset_async_w32: got %h expected %h", obs32, 38'd0); end
    @(posedge clk);
    #1;
    n_checks++; if (obs64 !== 70'd0) begin n_fails++; $display("FAIL midreset_discard_w64: got %h expected %h", obs64, 70'd0); end
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
  endtask

  task automatic test_back_to_back_random();
    logic [63:0] xa, xb;
    logic        xc;
    for (int i = 0; i < 10000; i++) begin
      if (i == 0) begin
        xa = '1; xb = '0; xc = 1'b1;
      end else begin
        xa = rnd64(); xb = rnd64(); xc = 1'($urandom);
      end
      drive(1'b1, xa[3:0], xb[3:0], xa[31:0], xb[31:0], xa, xb, xc, 1'b1);
      e4 = q4.pop_front(); e32 = q32.pop_front(); e64 = q64.pop_front();
      n_checks++; if (obs4 !== e4) begin n_fails++; $display("FAIL rand_w4[%0d]: got %h expected %h", i, obs4, e4); end
      n_checks++; if (obs32 !== e32) begin n_fails++; $display("FAIL rand_w32[%0d]: got %h expected %h", i, obs32, e32); end
      n_checks++; if (obs64 !== e64) begin n_fails++; $display("FAIL rand_w64[%0d]: got %h expected %h", i, obs64, e64); end
      if (i == 0) begin
        n_checks++;
        if (sum64 !== 64'd0 || cout64 !== 1'b1 || sum32 !== 32'd0 || cout32 !== 1'b1) begin
          n_fails++;
          $display("FAIL full_wrap: got sum64=%h cout64=%b sum32=%h cout32=%b expected all-zero sums with carry 1",
                   sum64, cout64, sum32, cout32);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; cin = 1'b0;
    a4 = '0; b4 = '0; a32 = '0; b32 = '0; a64 = '0; b64 = '0;
    last4 = '0; last32 = '0; last64 = '0;
    test_reset();
    test_zero();
    test_directed();
    test_hold();
    test_exhaustive();
    test_reset_midstream();
    test_back_to_back_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
